ppu_requant: RTL and testbench
==============================

// Module: ppu_requant
// PURPOSE
//   Post-processing unit downstream of the systolic array / ofmap GLB read path.
//   Per element: signed 32-bit accumulator + bias, optional ReLU, arithmetic
//   right-shift requantisation, clamp to int8, then pack 4 bytes per 32-bit word.
//   Strobes valid_ppu per packed word and pulses done once per WIDTH-element tile.
// PARAMETERS
//   WIDTH      64  elements per tile; must be a multiple of 4
//   ACC_W      32  accumulator / bias width (signed)
//   ADDR_W      6  output word address width; 2**ADDR_W >= WIDTH/4
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous reset, active-high
//   i_en_ppu   in   1        element valid; psum_in/bias_in sampled this cycle
//   psum_in    in   ACC_W    signed accumulator from ofmap GLB
//   bias_in    in   ACC_W    signed bias for this element
//   shift      in   5        requant right-shift amount (0..31), static per tile
//   relu_en    in   1        1 = apply ReLU, static per tile
//   valid_ppu  out  1        packed word valid (1-cycle strobe)
//   data_out   out  32       packed int8 x4; first element in [7:0]
//   out_addr   out  ADDR_W   word index within tile, 0..WIDTH/4-1
//   done       out  1        1-cycle pulse with last word of tile
// BEHAVIOUR
// - Reset (sync): valid_ppu=0, data_out=0, out_addr=0, done=0; all pipe valid
//   bits, byte counter, element counter cleared. Reset mid-tile discards the tile.
// - 3-stage pipeline, each stage carries a valid bit; bubbles (i_en_ppu=0) allowed
//   anywhere, no backpressure (consumer always accepts).
//   S1 (t+1): sum = psum_in + bias_in, saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   S2 (t+2): if relu_en && sum<0 -> 0; then r = sum >>> shift (arithmetic).
//   S3 (t+3): q = clamp(r, -128, 127); byte written to lane byte_cnt of pack reg.
// - Packing: byte_cnt 0..3 wraps; on lane 3 write valid_ppu=1 in the same cycle,
//   data_out = {b3,b2,b1,b0}. Latency: 4th element sampled at t4 -> valid_ppu at t4+3.
// - out_addr = index of word currently presented; increments the cycle after each
//   strobe; wraps to 0 after word WIDTH/4-1. data_out holds between strobes.
// - Element counter counts S3 valid elements; at element WIDTH-1: done=1 together
//   with final valid_ppu, counters return to 0. No partial words (WIDTH%4==0).
// - FSM: IDLE -> RUN on first i_en_ppu; RUN -> DRAIN when WIDTH-th element
//   accepted; DRAIN -> IDLE when it leaves S3 (done cycle). i_en_ppu in DRAIN or
//   the done cycle is accepted as element 0 of the next tile (pipeline overlaps).
// - More than WIDTH elements without rst: treated as next tile, never dropped.
// - shift/relu_en sampled at S2 per element; changing mid-tile is not supported.
// CONFIGURATION
//   PPU_ROUND_EN defined: S2 adds 1<<(shift-1) (when shift>0) to the ReLU'd value
//     in ACC_W+1 bits before the shift (round-half-up); no overflow possible.
//   Undefined: plain truncating arithmetic shift (floor). Latency unchanged.
// TESTING
// 1 psum {1,2,3,4}, bias 0, shift 0, relu 1, back-to-back -> valid_ppu at t4+3,
//   data_out=0x04030201, out_addr=0.
// 2 psum -50, bias 0: relu_en=1 -> byte 0x00; relu_en=0 -> byte 0xCE; psum 300
//   -> byte 0x7F; psum -300 relu 0 -> 0x80.
// 3 psum 0x7FFFFFF0 + bias 0x00000100, shift 24 -> sum saturates 0x7FFFFFFF,
//   byte 0x7F; psum 0x80000000 + bias -1 -> 0x80000000.
// 4 psum 6, shift 2: without PPU_ROUND_EN -> 1; with -> 2. psum -6, relu 0,
//   shift 2: without -> 0xFE; with -> 0xFF.
// 5 64 elements with random 1-3 cycle gaps -> exactly 16 strobes, out_addr 0..15,
//   done high only with 16th strobe; immediate second tile restarts at addr 0.
// 6 rst asserted after 10 elements -> next cycle all outputs 0; fresh 64-element
//   tile produces 16 words starting at out_addr 0, no stale bytes.

Source files
------------

// File: rtl/ppu_requant.sv
// ppu_requant: post-processing unit on the ofmap read path.
//   Per element: saturating psum + bias, optional ReLU, arithmetic right-shift
//   requantisation, clamp to int8, then pack four bytes per 32-bit word.
//   A valid bit travels with every element, so input bubbles are allowed
//   anywhere. There is no backpressure.
//
// Optional feature (macro PPU_ROUND_EN):
//   defined   - round-half-up: adds 1<<(shift-1) before the shift
//   undefined - plain truncating arithmetic shift (floor)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   i_en_ppu   element valid; psum_in/bias_in sampled this cycle
//   psum_in    signed accumulator
//   bias_in    signed bias for this element
//   shift      requant right-shift (0..31), static per tile
//   relu_en    apply ReLU, static per tile
//   valid_ppu  1-cycle strobe, packed word on data_out
//   data_out   packed int8 x4, first element in [7:0]; holds between strobes
//   out_addr   word index within tile of the word presented
//   done       1-cycle pulse together with the last word of a tile
//
// FSM (tile tracking on the input side)
//   state | meaning
//   IDLE  | no tile in flight
//   RUN   | accepting elements of a tile
//   DRAIN | all WIDTH elements accepted, last one still in the pipeline
module ppu_requant #(
  parameter int WIDTH  = 64,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en_ppu,
  input  logic signed [ACC_W-1:0] psum_in,
  input  logic signed [ACC_W-1:0] bias_in,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  output logic                    valid_ppu,
  output logic [31:0]             data_out,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WORDS = WIDTH / 4;

  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   Q_MAX   = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0]   Q_MIN   = (ACC_W+1)'(-128);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   in_cnt;
  logic               in_last;

  logic                    v1, v2;
  logic signed [ACC_W-1:0] sum1;
  logic signed [ACC_W:0]   r2;

  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [ACC_W-1:0] rel;
  logic signed [ACC_W:0]   pre_shift;
  logic signed [ACC_W:0]   shifted;
  logic [7:0]              q;

  logic [1:0]         byte_cnt;
  logic [23:0]        pack;
  logic [CNT_W-1:0]   elem_cnt;
  logic               last_elem;

  // ---------------- S1: add with saturation ----------------
  // One extra bit catches overflow; top two bits disagree on overflow.
  assign sum_ext = {psum_in[ACC_W-1], psum_in} + {bias_in[ACC_W-1], bias_in};

  always_comb begin
    sum_sat = sum_ext[ACC_W-1:0];
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
      sum_sat = sum_ext[ACC_W] ? SUM_MIN : SUM_MAX;
  end

  // ---------------- S2: ReLU, optional rounding, shift ----------------
  assign rel = (relu_en && sum1[ACC_W-1]) ? '0 : sum1;

`ifdef PPU_ROUND_EN
  logic signed [ACC_W:0] rnd_add;
  // The extra bit keeps rel + half-LSB from wrapping.
  assign rnd_add   = (shift != 5'd0) ? ((ACC_W+1)'(1) << (shift - 5'd1)) : '0;
  assign pre_shift = {rel[ACC_W-1], rel} + rnd_add;
`else
  assign pre_shift = {rel[ACC_W-1], rel};
`endif

  assign shifted = pre_shift >>> shift;

  // ---------------- S3: clamp to int8 ----------------
  always_comb begin
    q = r2[7:0];
    if (r2 > Q_MAX)
      q = 8'h7f;
    else if (r2 < Q_MIN)
      q = 8'h80;
  end

  assign last_elem = (elem_cnt == CNT_W'(WIDTH-1));

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      sum1 <= '0;
      r2   <= '0;
    end else begin
      v1 <= i_en_ppu;
      v2 <= v1;
      if (i_en_ppu) sum1 <= sum_sat;
      if (v1)       r2   <= shifted;
    end
  end

  // ---------------- packing and output ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      pack      <= '0;
      elem_cnt  <= '0;
      valid_ppu <= 1'b0;
      data_out  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      valid_ppu <= 1'b0;
      done      <= 1'b0;
      // Address steps the cycle after each strobe.
      if (valid_ppu)
        out_addr <= (out_addr == ADDR_W'(WORDS-1)) ? '0 : out_addr + 1'b1;
      if (v2) begin
        byte_cnt <= byte_cnt + 2'd1;
        elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
        case (byte_cnt)
          2'd0: pack[7:0]   <= q;
          2'd1: pack[15:8]  <= q;
          2'd2: pack[23:16] <= q;
          default: begin
            data_out  <= {q, pack};
            valid_ppu <= 1'b1;
            // WIDTH is a multiple of 4, so the last element always lands in lane 3.
            done      <= last_elem;
          end
        endcase
      end
    end
  end

  // ---------------- tile FSM ----------------
  assign in_last = (in_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      in_cnt <= '0;
    end else begin
      state <= state_nx;
      if (i_en_ppu)
        in_cnt <= in_last ? '0 : in_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_en_ppu) state_nx = in_last ? DRAIN : RUN;
      RUN:     if (i_en_ppu && in_last) state_nx = DRAIN;
      // A new element here starts the next tile while the old one drains.
      DRAIN:   if (i_en_ppu) state_nx = in_last ? DRAIN : RUN;
               else if (v2 && last_elem) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ppu_requant.sv
// tb_ppu_requant: directed, table-driven bench for ppu_requant.
//   Table of 4-element words with hand-computed packed results, plus
//   hand-written sequences for latency, mid-tile reset and full tiles.
//   Expected values follow PPU_ROUND_EN when the macro is defined.
module tb_ppu_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en_ppu;
  logic [31:0] psum_in;
  logic [31:0] bias_in;
  logic [4:0]  shift;
  logic        relu_en;
  logic        valid_ppu;
  logic [31:0] data_out;
  logic [5:0]  out_addr;
  logic        done;

  ppu_requant #(.WIDTH(64), .ACC_W(32), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en_ppu  (i_en_ppu),
    .psum_in   (psum_in),
    .bias_in   (bias_in),
    .shift     (shift),
    .relu_en   (relu_en),
    .valid_ppu (valid_ppu),
    .data_out  (data_out),
    .out_addr  (out_addr),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] psum;   // element j in psum[j]
    logic [3:0][31:0] bias;
    logic [4:0]       shift;
    logic             relu;
    logic [31:0]      exp;
  } vec_t;

  vec_t tbl [7];

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] b,
                       input logic [4:0] s, input logic r);
    @(negedge clk);
    i_en_ppu = 1'b1;
    psum_in  = p;
    bias_in  = b;
    shift    = s;
    relu_en  = r;
  endtask

  task automatic idle();
    @(negedge clk);
    i_en_ppu = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (valid_ppu) ok = 1'b1;
    end
  endtask

  // done must only ever appear together with a strobe
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      check("done_with_strobe", 32'(valid_ppu), 32'd1);
    end
  end

  initial begin
    bit ok;
    logic [31:0] exp_w;

    tbl[0] = '{{32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd0}}, 5'd0, 1'b1, 32'h04030201};
    tbl[1] = '{{-32'sd300, 32'd300, -32'sd50, -32'sd50}, {4{32'd0}}, 5'd0, 1'b0, 32'h807FCECE};
    tbl[2] = '{{32'd5, -32'sd300, 32'd300, -32'sd50}, {4{32'd0}}, 5'd0, 1'b1, 32'h05007F00};
    tbl[3] = '{{32'hFE000000, 32'h12345678, 32'h80000000, 32'h7FFFFFF0},
               {32'd0, 32'd0, 32'hFFFFFFFF, 32'h00000100}, 5'd24, 1'b0, 32'hFE12807F};
`ifdef PPU_ROUND_EN
    tbl[4] = '{{32'd7, 32'd5, -32'sd6, 32'd6}, {4{32'd0}}, 5'd2, 1'b0, 32'h0201FF02};
    tbl[5] = '{{32'd255, 32'd3, -32'sd10, 32'd10}, {32'd1, 32'd0, 32'd30, -32'sd20},
               5'd1, 1'b1, 32'h7F020A00};
    tbl[6] = '{{32'h40000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF}, {4{32'd0}},
               5'd31, 1'b0, 32'h01FF0100};
`else
    tbl[4] = '{{32'd7, 32'd5, -32'sd6, 32'd6}, {4{32'd0}}, 5'd2, 1'b0, 32'h0101FE01};
    tbl[5] = '{{32'd255, 32'd3, -32'sd10, 32'd10}, {32'd1, 32'd0, 32'd30, -32'sd20},
               5'd1, 1'b1, 32'h7F010A00};
    tbl[6] = '{{32'h40000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF}, {4{32'd0}},
               5'd31, 1'b0, 32'h00FF00FF};
`endif

    rst      = 1'b1;
    i_en_ppu = 1'b0;
    psum_in  = '0;
    bias_in  = '0;
    shift    = '0;
    relu_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_ppu), 32'd0);
    check("rst_data",  data_out,       32'd0);
    check("rst_addr",  32'(out_addr),  32'd0);
    check("rst_done",  32'(done),      32'd0);
    rst = 1'b0;

    // exact latency: 4th element sampled at t4, strobe visible in t4+3
    drive(32'd1, 32'd0, 5'd0, 1'b1);
    drive(32'd2, 32'd0, 5'd0, 1'b1);
    drive(32'd3, 32'd0, 5'd0, 1'b1);
    drive(32'd4, 32'd0, 5'd0, 1'b1);
    idle();
    check("lat_t4p1_valid", 32'(valid_ppu), 32'd0);
    @(negedge clk);
    check("lat_t4p2_valid", 32'(valid_ppu), 32'd0);
    @(negedge clk);
    check("lat_t4p3_valid", 32'(valid_ppu), 32'd1);
    check("lat_data",       data_out,       32'h04030201);
    check("lat_addr",       32'(out_addr),  32'd0);
    check("lat_done",       32'(done),      32'd0);
    @(negedge clk);
    check("lat_strobe_len", 32'(valid_ppu), 32'd0);
    check("lat_addr_step",  32'(out_addr),  32'd1);
    check("lat_data_hold",  data_out,       32'h04030201);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 4; j++)
        drive(tbl[i].psum[j], tbl[i].bias[j], tbl[i].shift, tbl[i].relu);
      idle();
      wait_strobe(10, ok);
      if (!ok) begin
        check($sformatf("vec%0d_timeout", i), 32'd0, 32'd1);
      end else begin
        check($sformatf("vec%0d_data", i), data_out,      tbl[i].exp);
        check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(i + 1));
        check($sformatf("vec%0d_done", i), 32'(done),     32'd0);
      end
    end

    // reset in the middle of a tile
    for (int k = 0; k < 10; k++) drive(32'd99, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    i_en_ppu = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(valid_ppu), 32'd0);
    check("midrst_data",  data_out,       32'd0);
    check("midrst_addr",  32'(out_addr),  32'd0);
    check("midrst_done",  32'(done),      32'd0);
    rst = 1'b0;

    // tile 1 with random gaps, tile 2 back-to-back right behind it;
    // element j carries value j, so word w is {4w+3,4w+2,4w+1,4w}
    fork
      begin
        for (int j = 0; j < 128; j++) begin
          drive(32'(j), 32'd0, 5'd0, 1'b0);
          if (j < 63) repeat ($urandom_range(0, 2)) idle();
        end
        idle();
      end
      begin
        for (int w = 0; w < 32; w++) begin
          wait_strobe(40, ok);
          if (!ok) begin
            check($sformatf("tile_w%0d_timeout", w), 32'd0, 32'd1);
            break;
          end
          exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
          check($sformatf("tile_w%0d_data", w), data_out,      exp_w);
          check($sformatf("tile_w%0d_addr", w), 32'(out_addr), 32'(w % 16));
          check($sformatf("tile_w%0d_done", w), 32'(done),     32'((w % 16) == 15));
        end
      end
    join

    repeat (6) idle();
    check("done_count",  32'(done_cnt),  32'd2);
    check("final_valid", 32'(valid_ppu), 32'd0);
    check("final_addr",  32'(out_addr),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
